pool_window_feeder: RTL and testbench

Row-pair window feeder that sits upstream of the 2x2 max-pooling stage. It accepts a raster pixel stream one pixel per cycle and buffers two full rows of `dataColNum` pixels. It then replays each 2x2 window to the pooler as two column beats, each beat carrying the pixel from the upper row and the pixel from the lower row. Input is back-pressured while the replay runs.

---
 rtl/pool_window_feeder.sv | 145 ++++++++++++++
 tb/tb_pool_window_feeder.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pool_window_feeder.sv
// Row-pair window feeder: buffers two raster rows, then replays each 2x2 window as two column beats.
// Optional macro POOL_GAP_EN inserts one idle cycle (out_valid low) after every window.
module pool_window_feeder #(
  parameter int dataColNum = 28,
  parameter int wordlength = 16,
  parameter int col_length = 5
) (
  input  logic                         clk,
  input  logic                         irst_n,
  input  logic                         in_valid,
  input  logic signed [wordlength-1:0] pixel_in,
  output logic                         in_ready,
  output logic signed [wordlength-1:0] pixels_0,
  output logic signed [wordlength-1:0] pixels_1,
  output logic                         out_valid,
  output logic                         win_last
);

  localparam int AW = (dataColNum > 1) ? $clog2(dataColNum) : 1;
  localparam logic [col_length-1:0] COL_LAST = col_length'(dataColNum - 1);
  localparam logic [col_length-1:0] WIN_LAST = col_length'(dataColNum / 2 - 1);

  typedef enum logic [2:0] {FILL0, FILL1, EMIT_A, EMIT_B, GAP} state_t;

  state_t                        state_q, state_d;
  logic [col_length-1:0]         col_q, col_d;
  logic [col_length-1:0]         k_q, k_d;
  logic                          out_valid_q, out_valid_d;
  logic                          win_last_q, win_last_d;
  logic signed [wordlength-1:0]  pixels_0_q, pixels_0_d;
  logic signed [wordlength-1:0]  pixels_1_q, pixels_1_d;

  logic signed [wordlength-1:0]  row0_mem [dataColNum];
  logic signed [wordlength-1:0]  row1_mem [dataColNum];

  logic                          accept;
  logic                          advance;
  logic                          load_pix;
  logic [col_length-1:0]         rd_idx;

  assign in_ready = (state_q == FILL0) || (state_q == FILL1);
  assign accept   = in_valid && in_ready;

  // NOTE: row buffers have no reset; every entry is rewritten during the fill before replay reads it.
  always_ff @(posedge clk) begin
    if (accept) begin
      if (state_q == FILL0) row0_mem[col_q[AW-1:0]] <= pixel_in;
      else                  row1_mem[col_q[AW-1:0]] <= pixel_in;
    end
  end

  always_comb begin
    // NOTE: every signal gets a default first so no path through the case infers a latch.
    state_d     = state_q;
    col_d       = col_q;
    k_d         = k_q;
    out_valid_d = 1'b0;
    win_last_d  = 1'b0;
    load_pix    = 1'b0;
    advance     = 1'b0;
    rd_idx      = '0;

    case (state_q)
      FILL0, FILL1: begin
        if (accept) begin
          if (col_q == COL_LAST) begin
            col_d = '0;
            if (state_q == FILL0) begin
              state_d = FILL1;
            end else begin
              state_d     = EMIT_A;
              k_d         = '0;
              out_valid_d = 1'b1;
              load_pix    = 1'b1;
              rd_idx      = '0;
            end
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      EMIT_A: begin
        state_d     = EMIT_B;
        out_valid_d = 1'b1;
        win_last_d  = 1'b1;
        load_pix    = 1'b1;
        rd_idx      = k_q + k_q + 1'b1;
      end
      EMIT_B: begin
`ifdef POOL_GAP_EN
        state_d = GAP;
`else
        advance = 1'b1;
`endif
      end
`ifdef POOL_GAP_EN
      GAP: advance = 1'b1;
`endif
      default: state_d = FILL0;
    endcase

    // Leaving a finished window: start the next one or return to filling.
    if (advance) begin
      if (k_q == WIN_LAST) begin
        state_d = FILL0;
      end else begin
        state_d     = EMIT_A;
        k_d         = k_q + 1'b1;
        out_valid_d = 1'b1;
        load_pix    = 1'b1;
        rd_idx      = k_d + k_d;
      end
    end

    pixels_0_d = load_pix ? row0_mem[rd_idx[AW-1:0]] : pixels_0_q;
    pixels_1_d = load_pix ? row1_mem[rd_idx[AW-1:0]] : pixels_1_q;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge irst_n) begin
    if (!irst_n) begin
      state_q     <= FILL0;
      col_q       <= '0;
      k_q         <= '0;
      out_valid_q <= 1'b0;
      win_last_q  <= 1'b0;
      pixels_0_q  <= '0;
      pixels_1_q  <= '0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      k_q         <= k_d;
      out_valid_q <= out_valid_d;
      win_last_q  <= win_last_d;
      pixels_0_q  <= pixels_0_d;
      pixels_1_q  <= pixels_1_d;
    end
  end

  assign out_valid = out_valid_q;
  assign win_last  = win_last_q;
  assign pixels_0  = pixels_0_q;
  assign pixels_1  = pixels_1_q;

endmodule

// File: tb/tb_pool_window_feeder.sv
// Self-checking bench for pool_window_feeder with 4-pixel rows (two windows per row pair).
// Expected beats are queued as row pairs are driven and compared when out_valid is seen.
module tb_pool_window_feeder;

  typedef logic signed [15:0] pix_t;
  typedef struct {
    pix_t p0;
    pix_t p1;
    logic last;
  } beat_t;

`ifdef POOL_GAP_EN
  localparam int RUN_LEN  = 2;
  localparam int BUSY_LEN = 6;
`else
  localparam int RUN_LEN  = 4;
  localparam int BUSY_LEN = 4;
`endif

  logic clk;
  logic irst_n;
  logic in_valid;
  pix_t pixel_in;
  logic in_ready;
  pix_t pixels_0;
  pix_t pixels_1;
  logic out_valid;
  logic win_last;

  int    n_checks = 0;
  int    n_fail   = 0;
  int    run_len  = 0;
  int    busy_len = 0;
  beat_t exp_q[$];
  beat_t mon_e;

  pool_window_feeder #(
    .dataColNum(4),
    .wordlength(16),
    .col_length(2)
  ) dut (
    .clk      (clk),
    .irst_n   (irst_n),
    .in_valid (in_valid),
    .pixel_in (pixel_in),
    .in_ready (in_ready),
    .pixels_0 (pixels_0),
    .pixels_1 (pixels_1),
    .out_valid(out_valid),
    .win_last (win_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard monitor plus run-length checks for out_valid and in_ready.
  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      run_len++;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_beat: got (%0d,%0d) with nothing expected", pixels_0, pixels_1);
      end else begin
        mon_e = exp_q.pop_front();
        if (pixels_0 !== mon_e.p0 || pixels_1 !== mon_e.p1 || win_last !== mon_e.last) begin
          n_fail++;
          $display("FAIL beat: got (%0d,%0d,last=%b) expected (%0d,%0d,last=%b)",
                   pixels_0, pixels_1, win_last, mon_e.p0, mon_e.p1, mon_e.last);
        end
      end
    end else begin
      if (run_len != 0) begin
        n_checks++;
        if (run_len != RUN_LEN) begin
          n_fail++;
          $display("FAIL out_valid_run: got %0d cycles expected %0d", run_len, RUN_LEN);
        end
        run_len = 0;
      end
      if (win_last === 1'b1) begin
        n_checks++;
        n_fail++;
        $display("FAIL win_last_idle: got 1 expected 0 while out_valid low");
      end
    end
    if (in_ready === 1'b0) begin
      busy_len++;
    end else if (in_ready === 1'b1 && busy_len != 0) begin
      n_checks++;
      if (busy_len != BUSY_LEN) begin
        n_fail++;
        $display("FAIL in_ready_low: got %0d cycles expected %0d", busy_len, BUSY_LEN);
      end
      busy_len = 0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic send_pixel(input pix_t v);
    int n = 0;
    in_valid = 1'b1;
    pixel_in = v;
    @(negedge clk);
    while (in_ready !== 1'b1 && n < 50) begin
      n++;
      @(negedge clk);
    end
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL accept_wait: got in_ready=%b expected 1 within 50 cycles", in_ready);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    pixel_in = pix_t'($urandom);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_pair(input pix_t r[8], input int gaps[8]);
    for (int k = 0; k < 2; k++) begin
      exp_q.push_back('{p0: r[2*k],   p1: r[4+2*k],   last: 1'b0});
      exp_q.push_back('{p0: r[2*k+1], p1: r[4+2*k+1], last: 1'b1});
    end
    for (int i = 0; i < 8; i++) begin
      send_pixel(r[i]);
      if (gaps[i] > 0) idle(gaps[i]);
    end
  endtask

  task automatic check_first_beat(input pix_t e0, input pix_t e1);
    n_checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0 || pixels_0 !== e0 || pixels_1 !== e1) begin
      n_fail++;
      $display("FAIL first_beat_latency: got valid=%b ready=%b (%0d,%0d) expected valid=1 ready=0 (%0d,%0d)",
               out_valid, in_ready, pixels_0, pixels_1, e0, e1);
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    in_valid = 1'b0;
    while ((exp_q.size() != 0 || in_ready !== 1'b1) && n < 200) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (exp_q.size() != 0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL drain: got %0d beats pending ready=%b expected 0 pending ready=1",
               exp_q.size(), in_ready);
    end
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_valid: got %b expected 0", out_valid);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || win_last !== 1'b0 ||
        pixels_0 !== 16'sd0 || pixels_1 !== 16'sd0) begin
      n_fail++;
      $display("FAIL %s: got ready=%b valid=%b last=%b p0=%0d p1=%0d expected 1 0 0 0 0",
               tag, in_ready, out_valid, win_last, pixels_0, pixels_1);
    end
  endtask

  task automatic test_reset();
    irst_n   = 1'b1;
    in_valid = 1'b0;
    pixel_in = '0;
    #2;
    irst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'($urandom);
      pixel_in = pix_t'($urandom);
      @(negedge clk);
      check_reset_outputs("reset_hold");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    irst_n   = 1'b1;
    @(negedge clk);
    check_reset_outputs("reset_release");
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    pix_t r[8];
    int   g[8];
    r = '{16'sd1, 16'sd2, 16'sd3, 16'sd4, 16'sd5, 16'sd6, 16'sd7, 16'sd8};
    g = '{0, 0, 0, 0, 0, 0, 0, 0};
    send_pair(r, g);
    check_first_beat(16'sd1, 16'sd5);
    wait_drain();
  endtask

  task automatic test_bubbles();
    pix_t r[8];
    int   g[8];
    r = '{16'sd1, 16'sd2, 16'sd3, 16'sd4, 16'sd5, 16'sd6, 16'sd7, 16'sd8};
    g = '{0, 3, 0, 0, 0, 1, 0, 0};
    send_pair(r, g);
    check_first_beat(16'sd1, 16'sd5);
    wait_drain();
  endtask

  task automatic test_ignored_and_sign();
    pix_t r[8];
    int   g[8];
    r = '{16'sd11, 16'sd12, 16'sd13, 16'sd14, 16'sd15, 16'sd16, 16'sd17, 16'sd18};
    g = '{0, 0, 0, 0, 0, 0, 0, 0};
    send_pair(r, g);
    in_valid = 1'b1;
    pixel_in = 16'sh1234;
    repeat (3) @(posedge clk);
    #1;
    r = '{16'sh8000, -16'sd1, 16'sd0, 16'sd32767, 16'sd5, -16'sd5, 16'sd7, -16'sd7};
    send_pair(r, g);
    check_first_beat(16'sh8000, 16'sd5);
    wait_drain();
  endtask

  task automatic test_reset_mid_replay();
    pix_t r[8];
    int   g[8];
    int   n = 0;
    r = '{16'sd1, 16'sd2, 16'sd3, 16'sd4, 16'sd5, 16'sd6, 16'sd7, 16'sd8};
    g = '{0, 0, 0, 0, 0, 0, 0, 0};
    send_pair(r, g);
    in_valid = 1'b0;
    while (!(out_valid === 1'b1 && pixels_0 === 16'sd3) && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    n_checks++;
    if (!(out_valid === 1'b1 && pixels_0 === 16'sd3 && pixels_1 === 16'sd7)) begin
      n_fail++;
      $display("FAIL beat_3_7_seen: got valid=%b (%0d,%0d) expected valid=1 (3,7)",
               out_valid, pixels_0, pixels_1);
    end
    irst_n = 1'b0;
    run_len  = 0;
    busy_len = 0;
    exp_q.delete();
    #1;
    check_reset_outputs("reset_mid_replay");
    repeat (2) @(posedge clk);
    #1;
    irst_n = 1'b1;
    check_reset_outputs("release_mid_replay");

    // Partial fill discarded by a second reset.
    send_pixel(16'sd50);
    send_pixel(16'sd51);
    send_pixel(16'sd52);
    in_valid = 1'b0;
    irst_n   = 1'b0;
    @(posedge clk);
    #1;
    irst_n = 1'b1;

    r = '{16'sd20, 16'sd21, 16'sd22, 16'sd23, 16'sd24, 16'sd25, 16'sd26, 16'sd27};
    send_pair(r, g);
    check_first_beat(16'sd20, 16'sd24);
    wait_drain();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bubbles();
    test_ignored_and_sign();
    test_reset_mid_replay();
    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
